// File: rtl/smart_counter_pkg.sv
// Shared definitions for the smart_counter slice.
//   SC_WIDTH_DEF : default counter width
//   sc_op_e      : per-edge operation selected by the next-count logic
//   sc_max()     : all-ones value for a given width (width 1..64)
package smart_counter_pkg;

  localparam int unsigned SC_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    SC_OP_HOLD = 2'd0,
    SC_OP_INC  = 2'd1,
    SC_OP_LOAD = 2'd2
  } sc_op_e;

  function automatic logic [63:0] sc_max(input int unsigned width);
    logic [63:0] ones;
    ones = '1;
    return ones >> (64 - width);
  endfunction

endpackage

// File: rtl/smart_counter_next.sv
// Combinational next-count logic for smart_counter.
// Priority: load > enable > hold. Increment wraps modulo 2^WIDTH, or
// saturates at all-ones when SMART_COUNTER_SAT_EN is defined.
// Ports:
//   count      in   WIDTH  current registered count
//   load       in   1      load strobe
//   enable     in   1      count enable
//   data_in    in   WIDTH  load value
//   count_nxt  out  WIDTH  value to register on the next edge
module smart_counter_next
  import smart_counter_pkg::*;
#(
  parameter int unsigned WIDTH = SC_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] count,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count_nxt
);

`ifdef SMART_COUNTER_SAT_EN
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(sc_max(WIDTH));
`endif

  sc_op_e op;

  always_comb begin
    op = SC_OP_HOLD;
    if (load) begin
      op = SC_OP_LOAD;
    end else if (enable) begin
      op = SC_OP_INC;
    end
  end

  always_comb begin
    count_nxt = count;
    case (op)
      SC_OP_LOAD: count_nxt = data_in;
      SC_OP_INC: begin
`ifdef SMART_COUNTER_SAT_EN
        if (count != CNT_MAX) begin
          count_nxt = count + 1'b1;
        end
`else
        count_nxt = count + 1'b1;
`endif
      end
      default: count_nxt = count;
    endcase
  end

endmodule

// File: rtl/smart_counter.sv
// Loadable, enable-gated up counter with terminal-count flag.
// Optional macro SMART_COUNTER_SAT_EN: increment saturates at all-ones
// instead of wrapping to zero.
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous active-low reset, clears count
//   load     in   1      synchronous load strobe (highest priority)
//   enable   in   1      synchronous count enable
//   data_in  in   WIDTH  value captured when load = 1
//   count    out  WIDTH  registered counter value
//   tc       out  1      combinational, 1 when count is all-ones
module smart_counter
  import smart_counter_pkg::*;
#(
  parameter int unsigned WIDTH = SC_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(sc_max(WIDTH));

  logic [WIDTH-1:0] count_nxt;

  smart_counter_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .count    (count),
    .load     (load),
    .enable   (enable),
    .data_in  (data_in),
    .count_nxt(count_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  assign tc = (count == CNT_MAX);

endmodule

// File: tb/tb_smart_counter.sv
// Self-checking bench for smart_counter (WIDTH = 8), default or
// SMART_COUNTER_SAT_EN build.
module tb_smart_counter;

  logic       clk;
  logic       rst;
  logic       load;
  logic       enable;
  logic [7:0] data_in;
  logic [7:0] count;
  logic       tc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       ld;
    logic       en;
    logic [7:0] d;
    logic [7:0] c;
    logic       t;
  } vec_t;

  typedef struct {
    logic [7:0] c;
    logic       t;
    string      nm;
  } exp_t;

  exp_t sb[$];

`ifdef SMART_COUNTER_SAT_EN
  localparam logic [7:0] WRAP_C = 8'hFF;
  localparam logic       WRAP_T = 1'b1;
`else
  localparam logic [7:0] WRAP_C = 8'h00;
  localparam logic       WRAP_T = 1'b0;
`endif

  smart_counter #(
    .WIDTH(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .enable (enable),
    .data_in(data_in),
    .count  (count),
    .tc     (tc)
  );

  // First rising edge at 10 ns so the 3..8 ns reset window has no edge.
  initial begin
    clk = 1'b0;
    #10;
    forever begin
      clk = 1'b1;
      #5;
      clk = 1'b0;
      #5;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pop_and_check();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: empty queue at %0t", $time);
    end else begin
      e = sb.pop_front();
      chk({e.nm, "_count"}, count, e.c);
      chk({e.nm, "_tc"}, {7'd0, tc}, {7'd0, e.t});
    end
  endtask

  task automatic step(input logic ld, input logic en, input logic [7:0] d,
                      input logic [7:0] ec, input logic et, input string nm);
    exp_t e;
    @(negedge clk);
    load    = ld;
    enable  = en;
    data_in = d;
    e.c  = ec;
    e.t  = et;
    e.nm = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_and_check();
  endtask

  vec_t v1[6];
  vec_t v2[9];

  initial begin
    v1[0] = '{1'b1, 1'b0, 8'h55, 8'h55, 1'b0};
    v1[1] = '{1'b0, 1'b1, 8'h00, 8'h56, 1'b0};
    v1[2] = '{1'b0, 1'b1, 8'h00, 8'h57, 1'b0};
    v1[3] = '{1'b0, 1'b1, 8'h00, 8'h58, 1'b0};
    v1[4] = '{1'b0, 1'b0, 8'hAA, 8'h58, 1'b0};
    v1[5] = '{1'b0, 1'b0, 8'h00, 8'h58, 1'b0};

    v2[0] = '{1'b1, 1'b0, 8'hF0, 8'hF0, 1'b0};
    v2[1] = '{1'b0, 1'b1, 8'h00, 8'hF1, 1'b0};
    v2[2] = '{1'b0, 1'b1, 8'h00, 8'hF2, 1'b0};
    v2[3] = '{1'b1, 1'b1, 8'h10, 8'h10, 1'b0};
    v2[4] = '{1'b1, 1'b0, 8'hFE, 8'hFE, 1'b0};
    v2[5] = '{1'b0, 1'b1, 8'h00, 8'hFF, 1'b1};
    v2[6] = '{1'b0, 1'b1, 8'h00, WRAP_C, WRAP_T};
    v2[7] = '{1'b1, 1'b0, 8'h20, 8'h20, 1'b0};
    v2[8] = '{1'b0, 1'b1, 8'h00, 8'h21, 1'b0};

    rst     = 1'b1;
    load    = 1'b0;
    enable  = 1'b0;
    data_in = 8'h00;

    #3 rst = 1'b0;
    #5;
    chk("reset_count", count, 8'h00);
    chk("reset_tc", {7'd0, tc}, 8'h00);

    #4 rst = 1'b1;

    foreach (v1[i]) step(v1[i].ld, v1[i].en, v1[i].d, v1[i].c, v1[i].t, $sformatf("v1_%0d", i));

    // Reset between edges must clear count within 2 ns.
    load   = 1'b0;
    enable = 1'b0;
    #2 rst = 1'b0;
    #2;
    chk("midreset_count", count, 8'h00);
    chk("midreset_tc", {7'd0, tc}, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    foreach (v2[i]) step(v2[i].ld, v2[i].en, v2[i].d, v2[i].c, v2[i].t, $sformatf("v2_%0d", i));

    // Load 0xFF then hold: tc stays high.
    step(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, "load_ff");
    step(1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, "hold_ff");

    // Reset asserted while a load is pending: the load must not survive.
    @(negedge clk);
    load    = 1'b1;
    enable  = 1'b1;
    data_in = 8'hAA;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_load_count", count, 8'h00);
    chk("rst_load_tc", {7'd0, tc}, 8'h00);
    @(negedge clk);
    load   = 1'b0;
    enable = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    chk("after_rst_load_count", count, 8'h00);

    step(1'b0, 1'b1, 8'h00, 8'h01, 1'b0, "post_rst_inc");

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
